// File: rtl/seq_detect_prog_if.sv
// Serial-stream and configuration bundle for the programmable pattern detector.
// master drives the stream and the config; slave is the detector.
interface seq_detect_prog_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               data;
    logic               data_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               flag;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output data, data_valid, cfg_load, cfg_pat, cfg_len, cfg_ovl,
        input  flag, match_cnt, cfg_err
    );

    modport slave (
        input  data, data_valid, cfg_load, cfg_pat, cfg_len, cfg_ovl,
        output flag, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlap/non-overlap matching,
// a one-cycle match flag and a saturating match counter.
module seq_detect_prog #(
    parameter int unsigned        MAX_LEN = 8,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
    parameter int unsigned        DEF_LEN = 4,
    parameter bit                 DEF_OVL = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seq_detect_prog_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [0:0] {ACTIVE, CFG_BAD} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] hist_nx_c;
    logic [LEN_W-1:0]   fill_nx_c;
    logic [MAX_LEN-1:0] mask_c;
    logic               legal_c;
    logic               hit_c;

    // Candidate history/fill after accepting the current bit, and the match test on them.
    always_comb begin
        hist_nx_c = {hist_q[MAX_LEN-2:0], bus.data};
        fill_nx_c = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        mask_c    = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask_c[i] = (i < 32'(len_q));
        end
        legal_c = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        hit_c   = bus.data_valid && (state_q == ACTIVE)
                  && (((hist_nx_c ^ pat_q) & mask_c) == '0)
                  && (fill_nx_c >= len_q);
    end

    // Next-state and datapath update; a config load takes priority over data.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        flag_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ACTIVE:  if (bus.cfg_load && !legal_c) state_d = CFG_BAD;
            CFG_BAD: if (bus.cfg_load && legal_c)  state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase

        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pat;
            len_d  = bus.cfg_len;
            ovl_d  = bus.cfg_ovl;
            hist_d = '0;
            fill_d = '0;
            err_d  = !legal_c;
        end else if (bus.data_valid) begin
            hist_d = hist_nx_c;
            fill_d = fill_nx_c;
            if (hit_c) begin
                flag_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                // Non-overlap: the matching bit is consumed, so restart the fill.
                if (!ovl_q) fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACTIVE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEF_PAT;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= DEF_OVL;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.flag      = flag_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog (MAX_LEN=8, CNT_W=3 so saturation is reachable).
module tb_seq_detect_prog;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock with the given stream inputs; flag checked just after the edge.
    task automatic step(input logic d, input logic v, input logic ef, input string tag);
        bus.data       = d;
        bus.data_valid = v;
        bus.cfg_load   = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, 32'(bus.flag), 32'(ef));
    endtask

    // n valid bits, bits[n-1] sent first, flags[n-1] is the expectation for the first bit.
    task automatic stream(input logic [15:0] bits, input logic [15:0] flags, input int n,
                          input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, flags[i], $sformatf("%s_b%0d", tag, n - 1 - i));
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic dv, input string tag);
        bus.cfg_load   = 1'b1;
        bus.cfg_pat    = pat;
        bus.cfg_len    = len;
        bus.cfg_ovl    = ovl;
        bus.data_valid = dv;
        bus.data       = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_load   = 1'b0;
        bus.data_valid = 1'b0;
        chk({tag, "_flag"}, 32'(bus.flag), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, "_flag"}, 32'(bus.flag), 32'd0);
        chk({tag, "_cnt"},  32'(bus.match_cnt), 32'd0);
        chk({tag, "_err"},  32'(bus.cfg_err), 32'd0);
    endtask

    initial begin
        bus.data = 1'b0; bus.data_valid = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_ovl = 1'b0;
        @(posedge clk);
        do_reset("rst0");

        // Default 1011, overlapping: shared '1' yields a second match.
        stream(16'b1011011, 16'b0001001, 7, "t1");
        chk("t1_cnt", 32'(bus.match_cnt), 32'd2);

        // Pattern 11, non-overlap then overlap.
        do_reset("rst1");
        load(8'b11, 4'd2, 1'b0, 1'b0, "t2_ld0");
        stream(16'b11111, 16'b01010, 5, "t2_nov");
        chk("t2_cnt_nov", 32'(bus.match_cnt), 32'd2);
        load(8'b11, 4'd2, 1'b1, 1'b0, "t2_ld1");
        stream(16'b11111, 16'b01111, 5, "t2_ovl");
        chk("t2_cnt_ovl", 32'(bus.match_cnt), 32'd6);

        // data_valid gaps must not shift the history.
        do_reset("rst2");
        step(1'b1, 1'b1, 1'b0, "t3_v0");
        step(1'b0, 1'b1, 1'b0, "t3_v1");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, $sformatf("t3_gap%0d", i));
        step(1'b1, 1'b1, 1'b0, "t3_v2");
        step(1'b1, 1'b1, 1'b1, "t3_v3");
        step(1'b1, 1'b0, 1'b0, "t3_after");
        chk("t3_cnt", 32'(bus.match_cnt), 32'd1);

        // Full-length all-zero pattern: fill gates the reset-zero history.
        load(8'h00, 4'd8, 1'b0, 1'b0, "t4_ld0");
        stream(16'h00, 16'b00000001, 8, "t4_nov");
        stream(16'b000, 16'b000, 3, "t4_nov_tail");
        load(8'h00, 4'd8, 1'b1, 1'b0, "t4_ld1");
        stream(16'h00, 16'b00000001, 8, "t4_ovl");
        stream(16'b00, 16'b11, 2, "t4_ovl_tail");
        chk("t4_cnt", 32'(bus.match_cnt), 32'd5);

        // Illegal lengths disable detection; legal load recovers; pat bits above len ignored.
        load(8'b1011, 4'd0, 1'b1, 1'b0, "t5_len0");
        chk("t5_err_len0", 32'(bus.cfg_err), 32'd1);
        stream(16'b1011, 16'b0000, 4, "t5_bad");
        load(8'b1011, 4'd9, 1'b1, 1'b0, "t5_len9");
        chk("t5_err_len9", 32'(bus.cfg_err), 32'd1);
        load(8'hFB, 4'd4, 1'b1, 1'b0, "t5_good");
        chk("t5_err_clr", 32'(bus.cfg_err), 32'd0);
        stream(16'b1011, 16'b0001, 4, "t5_m");
        chk("t5_cnt6", 32'(bus.match_cnt), 32'd6);
        // Load with data_valid mid-pattern: bit dropped, partial match discarded.
        stream(16'b101, 16'b000, 3, "t5_part");
        load(8'b1011, 4'd4, 1'b1, 1'b1, "t5_ld_dv");
        stream(16'b1011, 16'b0001, 4, "t5_fresh");
        chk("t5_cnt7", 32'(bus.match_cnt), 32'd7);

        // Saturation at 7 after matches 8 and 9.
        stream(16'b011, 16'b001, 3, "t6_m8");
        stream(16'b011, 16'b001, 3, "t6_m9");
        chk("t6_sat", 32'(bus.match_cnt), 32'd7);

        // Async reset while flag is high: outputs clear before the next edge.
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_flag", 32'(bus.flag), 32'd0);
        chk("t6_arst_cnt",  32'(bus.match_cnt), 32'd0);
        #1 rst = 1'b0;
        load(8'b0, 4'd0, 1'b0, 1'b0, "t6_bad");
        chk("t6_err_set", 32'(bus.cfg_err), 32'd1);
        step(1'b1, 1'b1, 1'b0, "t6_part0");
        step(1'b0, 1'b1, 1'b0, "t6_part1");
        #3 rst = 1'b1;
        #1;
        chk("t6_arst_err", 32'(bus.cfg_err), 32'd0);
        #1 rst = 1'b0;
        // Default 1011 overlapping restored, partial pattern gone.
        stream(16'b1011011, 16'b0001001, 7, "t6_def");
        chk("t6_cnt_def", 32'(bus.match_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
